// File: rtl/regfile_scoreboard.sv
// Integer register file with a hardwired-zero x0, NRD combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard for decode stalls.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                WriteEn,
  input  logic [AW-1:0]       WriteAddr,
  input  logic [XLEN-1:0]     WriteData,
  input  logic [NRD*AW-1:0]   ReadAddr,
  output logic [NRD*XLEN-1:0] ReadData,
  output logic [NRD-1:0]      ReadBusy,
  input  logic                IssueEn,
  input  logic [AW-1:0]       IssueAddr,
  input  logic                Flush,
  output logic [NREGS-1:0]    BusyVec
);

  // An address names a real, writable register: not x0 and inside the file
  // (NREGS need not be a power of two, so the top codes can be holes).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_valid;
  logic             iss_valid;

  assign wr_valid  = WriteEn && addr_ok(WriteAddr);
  assign iss_valid = IssueEn && addr_ok(IssueAddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[WriteAddr] <= WriteData;
    end
  end

  // Issue outranks a same-cycle writeback: the newer producer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (Flush) begin
      busy_d = '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (iss_valid && (IssueAddr == AW'(r))) begin
          busy_d[r] = 1'b1;
        end else if (wr_valid && (WriteAddr == AW'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign BusyVec = busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic          ra_ok;
      logic          fwd;

      assign ra    = ReadAddr[gi*AW +: AW];
      assign ra_ok = addr_ok(ra);
      assign fwd   = (BYPASS != 0) && wr_valid && (WriteAddr == ra);

      always_comb begin
        ReadData[gi*XLEN +: XLEN] = '0;
        ReadBusy[gi]              = 1'b0;
        if (ra_ok) begin
          if (fwd) begin
            ReadData[gi*XLEN +: XLEN] = WriteData;
          end else begin
            ReadData[gi*XLEN +: XLEN] = regs_q[ra];
            ReadBusy[gi]              = busy_q[ra];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives three configurations (bypass 32x2, no-bypass 32x2, 24x4) from shared stimulus
// and checks every port each cycle against an array model, plus literal spot checks.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst, we, ie, fl;
  logic [4:0]  wa, ia;
  logic [31:0] wd;
  logic [4:0]  ra [4];

  logic [63:0]  rd_a, rd_b;
  logic [127:0] rd_c;
  logic [1:0]   rb_a, rb_b;
  logic [3:0]   rb_c;
  logic [31:0]  bv_a, bv_b;
  logic [23:0]  bv_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .WriteEn(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr({ra[1], ra[0]}), .ReadData(rd_a), .ReadBusy(rb_a),
    .IssueEn(ie), .IssueAddr(ia), .Flush(fl), .BusyVec(bv_a));

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .WriteEn(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr({ra[1], ra[0]}), .ReadData(rd_b), .ReadBusy(rb_b),
    .IssueEn(ie), .IssueAddr(ia), .Flush(fl), .BusyVec(bv_b));

  regfile_scoreboard #(.XLEN(32), .NREGS(24), .NRD(4), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .WriteEn(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr({ra[3], ra[2], ra[1], ra[0]}), .ReadData(rd_c), .ReadBusy(rb_c),
    .IssueEn(ie), .IssueAddr(ia), .Flush(fl), .BusyVec(bv_c));

  // Architectural model: one register array and busy array per configuration
  int          ncfg [3] = '{32, 32, 24};
  int          nrdc [3] = '{2, 2, 4};
  bit          bcfg [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_reg  [3][32];
  bit          m_busy [3][32];
  bit          mvalid = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", n, $time, act, exp);
    end
  endtask

  task automatic mread(input int c, input logic [4:0] a, output logic [31:0] d, output logic b);
    if (a == 5'd0 || int'(a) >= ncfg[c]) begin
      d = '0; b = 1'b0;
    end else if (bcfg[c] && we && wa == a) begin
      d = wd; b = 1'b0;
    end else begin
      d = m_reg[c][a]; b = m_busy[c][a];
    end
  endtask

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_reg[c][r]  <= '0;
          m_busy[c][r] <= 1'b0;
        end
      end else begin
        if (we && wa != 0 && int'(wa) < ncfg[c]) m_reg[c][wa] <= wd;
        if (fl) begin
          for (int r = 0; r < 32; r++) m_busy[c][r] <= 1'b0;
        end else begin
          if (we && wa != 0 && int'(wa) < ncfg[c]) m_busy[c][wa] <= 1'b0;
          if (ie && ia != 0 && int'(ia) < ncfg[c]) m_busy[c][ia] <= 1'b1;
        end
      end
    end
    if (rst) mvalid <= 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int c = 0; c < 3; c++) begin
        logic [31:0] ed, ad, ebv, abv;
        logic        eb, ab;
        for (int p = 0; p < nrdc[c]; p++) begin
          mread(c, ra[p], ed, eb);
          case (c)
            0:       begin ad = rd_a[p*32 +: 32]; ab = rb_a[p]; end
            1:       begin ad = rd_b[p*32 +: 32]; ab = rb_b[p]; end
            default: begin ad = rd_c[p*32 +: 32]; ab = rb_c[p]; end
          endcase
          chk($sformatf("cfg%0d_rdata%0d", c, p), ad, ed);
          chk($sformatf("cfg%0d_rbusy%0d", c, p), {31'b0, ab}, {31'b0, eb});
        end
        ebv = '0;
        for (int r = 0; r < ncfg[c]; r++) ebv[r] = m_busy[c][r];
        abv = (c == 0) ? bv_a : (c == 1) ? bv_b : {8'b0, bv_c};
        chk($sformatf("cfg%0d_busyvec", c), abv, ebv);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic i, input logic [4:0] ib, input logic f);
    rst = r; we = w; wa = a; wd = d; ie = i; ia = ib; fl = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    for (int p = 0; p < 4; p++) ra[p] = 5'd0;
    step();

    // Fill some registers and a busy bit, then reset over a competing write/issue
    for (int r = 1; r <= 10; r++) begin
      drive(1'b0, 1'b1, 5'(r), 32'(r * 17), 1'b0, 5'd0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0);
    step();
    drive(1'b1, 1'b1, 5'd2, 32'h77, 1'b1, 5'd5, 1'b0);
    step();
    idle(); ra[0] = 5'd3; ra[1] = 5'd2;
    #3;
    chk("rst_rd0", rd_a[31:0], 32'h0);
    chk("rst_rd1", rd_a[63:32], 32'h0);
    chk("rst_busyvec", bv_a, 32'h0);
    step();
    drive(1'b0, 1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 1'b0);
    step();
    idle(); ra[0] = 5'd5;
    #3;
    chk("post_rst_reg5", rd_a[31:0], 32'h5);
    step();

    // x0 is immutable and never busy
    drive(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0);
    ra[0] = 5'd0; ra[1] = 5'd0;
    #3;
    chk("x0_bypass_rd", rd_a[31:0], 32'h0);
    step();
    idle();
    #3;
    chk("x0_rd", rd_a[31:0], 32'h0);
    chk("x0_busy", {31'b0, bv_a[0]}, 32'h0);
    step();

    // Bypass vs. no bypass
    drive(1'b0, 1'b1, 5'd7, 32'd30, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, 1'b1, 5'd7, 32'd99, 1'b0, 5'd0, 1'b0);
    ra[1] = 5'd7;
    #3;
    chk("byp_on_rd1", rd_a[63:32], 32'd99);
    chk("byp_off_rd1", rd_b[63:32], 32'd30);
    step();
    idle();
    #3;
    chk("byp_off_next", rd_b[63:32], 32'd99);
    step();

    // Scoreboard set/clear and issue-beats-writeback
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0);
    step();
    idle(); ra[0] = 5'd9;
    #3;
    chk("sb_busy9", {31'b0, rb_a[0]}, 32'd1);
    step();
    drive(1'b0, 1'b1, 5'd9, 32'd40, 1'b0, 5'd0, 1'b0);
    #3;
    chk("sb_wb_busy", {31'b0, rb_a[0]}, 32'd0);
    chk("sb_wb_data", rd_a[31:0], 32'd40);
    chk("sb_wb_busy_nobyp", {31'b0, rb_b[0]}, 32'd1);
    step();
    drive(1'b0, 1'b1, 5'd9, 32'd41, 1'b1, 5'd9, 1'b0);
    step();
    idle();
    #3;
    chk("sb_iss_wins", {31'b0, bv_a[9]}, 32'd1);
    chk("sb_iss_wins_data", rd_a[31:0], 32'd41);
    step();

    // Flush clears everything, kills the same-cycle issue, keeps the write
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0); step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0); step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0); step();
    idle();
    #3;
    chk("pre_flush_busyvec", bv_a, 32'h350);
    drive(1'b0, 1'b1, 5'd6, 32'd22, 1'b1, 5'd10, 1'b1);
    step();
    idle(); ra[0] = 5'd6;
    #3;
    chk("flush_busyvec", bv_a, 32'h0);
    chk("flush_reg6", rd_a[31:0], 32'd22);
    step();

    // Out-of-range address on the 24-entry, 4-port instance
    drive(1'b0, 1'b1, 5'd30, 32'h1234, 1'b0, 5'd0, 1'b0);
    ra[0] = 5'd30;
    #3;
    chk("oor_rd", rd_c[31:0], 32'h0);
    chk("oor_busy", {31'b0, rb_c[0]}, 32'h0);
    step();
    drive(1'b0, 1'b1, 5'd23, 32'hABC, 1'b0, 5'd0, 1'b0); step();
    drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 1'b0); step();
    idle();
    ra[0] = 5'd23; ra[1] = 5'd1; ra[2] = 5'd5; ra[3] = 5'd30;
    #3;
    chk("p4_rd0", rd_c[31:0], 32'hABC);
    chk("p4_rd1", rd_c[63:32], 32'h11);
    chk("p4_rd2", rd_c[95:64], 32'h5);
    chk("p4_rd3", rd_c[127:96], 32'h0);
    step();

    // Mixed traffic, compared every cycle against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
            $urandom, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 11) == 0));
      for (int p = 0; p < 4; p++) begin
        ra[p] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      end
      step();
    end

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
